// File: rtl/traffic_pkg.sv
// Shared constants for the intersection: light one-hot codes, timer states and FSM phases.
package traffic_pkg;

  localparam int LIGHT_W_DEF = 3;

  localparam logic [2:0] LIGHT_OFF    = 3'b000;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  // Largest value the two-digit display can show; anything above saturates.
  localparam int BCD_MAX = 99;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_EXPIRED = 2'd2
  } timer_state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

endpackage

// File: rtl/traffic_bin2bcd.sv
// Binary-to-two-digit-BCD converter for the remaining-seconds display, saturating at 99.
module traffic_bin2bcd
  import traffic_pkg::*;
#(
  parameter int CNT_WIDTH = 7
) (
  input  logic [CNT_WIDTH-1:0] bin_i,
  output logic [3:0]           tens_o,
  output logic [3:0]           ones_o
);

  logic [7:0] bcd;

  // Double-dabble over the input bits; out-of-range values are clamped to 9/9.
  always_comb begin
    bcd = 8'h00;
    if (32'(bin_i) > 32'(BCD_MAX)) begin
      bcd = 8'h99;
    end else begin
      for (int i = CNT_WIDTH - 1; i >= 0; i--) begin
        if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
        bcd = {bcd[6:0], bin_i[i]};
      end
    end
  end

  assign tens_o = bcd[7:4];
  assign ones_o = bcd[3:0];

endmodule

// File: rtl/traffic_phase_timer.sv
// Per-phase countdown timer for traffic_fsm: loads the selected duration, counts
// whole seconds off a prescaler and pulses last_cnt when the phase runs out.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_WIDTH = 7,
  parameter int TICK_DIV  = 50_000_000,
  parameter int LIGHT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [LIGHT_W-1:0]   cnt_init,
  input  logic [CNT_WIDTH-1:0] green_time,
  input  logic [CNT_WIDTH-1:0] yellow_time,
  input  logic [CNT_WIDTH-1:0] red_time,
  output logic                 last_cnt,
  output logic                 sec_tick,
  output logic [CNT_WIDTH-1:0] remaining,
  output logic [3:0]           rem_tens,
  output logic [3:0]           rem_ones
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  timer_state_e         state_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [PRESC_W-1:0]   presc_q;
  logic                 lastCnt_q;
  logic                 secTick_q;

  logic                 loadReq;
  logic [CNT_WIDTH-1:0] selDur;
  logic [CNT_WIDTH-1:0] loadDur_d;

  // Pick the duration to load: green on arming from IDLE, otherwise one-hot
  // request with green > yellow > red priority. A zero duration becomes 1 s.
  always_comb begin
    loadReq = (state_q == T_IDLE) || (cnt_init != '0);
    selDur  = red_time;
    if (state_q == T_IDLE) begin
      selDur = green_time;
    end else if (|(cnt_init & LIGHT_W'(LIGHT_GREEN))) begin
      selDur = green_time;
    end else if (|(cnt_init & LIGHT_W'(LIGHT_YELLOW))) begin
      selDur = yellow_time;
    end
    loadDur_d = (selDur == '0) ? CNT_WIDTH'(1) : selDur;
  end

  // Timer FSM: enable drop clears everything, a load restarts the phase,
  // RUN counts down one second per prescaler wrap, EXPIRED waits for a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= T_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      lastCnt_q <= 1'b0;
      secTick_q <= 1'b0;
    end else if (!en) begin
      state_q   <= T_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      lastCnt_q <= 1'b0;
      secTick_q <= 1'b0;
    end else if (loadReq) begin
      state_q   <= T_RUN;
      count_q   <= loadDur_d;
      presc_q   <= '0;
      lastCnt_q <= 1'b0;
      secTick_q <= 1'b0;
    end else begin
      case (state_q)
        T_RUN: begin
          if (presc_q == PRESC_MAX) begin
            presc_q   <= '0;
            secTick_q <= 1'b1;
            count_q   <= count_q - CNT_WIDTH'(1);
            if (count_q == CNT_WIDTH'(1)) begin
              state_q   <= T_EXPIRED;
              lastCnt_q <= 1'b1;
            end else begin
              lastCnt_q <= 1'b0;
            end
          end else begin
            presc_q   <= presc_q + PRESC_W'(1);
            secTick_q <= 1'b0;
            lastCnt_q <= 1'b0;
          end
        end
        T_EXPIRED: begin
          count_q   <= '0;
          presc_q   <= '0;
          lastCnt_q <= 1'b0;
          secTick_q <= 1'b0;
        end
        default: begin
          state_q   <= T_IDLE;
          count_q   <= '0;
          presc_q   <= '0;
          lastCnt_q <= 1'b0;
          secTick_q <= 1'b0;
        end
      endcase
    end
  end

  assign last_cnt  = lastCnt_q;
  assign sec_tick  = secTick_q;
  assign remaining = count_q;

  traffic_bin2bcd #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_bin2bcd (
    .bin_i (count_q),
    .tens_o(rem_tens),
    .ones_o(rem_ones)
  );

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer with a behavioural traffic_fsm stand-in; every
// sec_tick/last_cnt pulse is matched against a queue of expected events.
module tb_traffic_phase_timer;
  import traffic_pkg::*;

  localparam int TICK = 4;
  localparam int CW   = 7;
  localparam int LW   = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic [LW-1:0] cnt_init;
  logic [CW-1:0] green_time  = 7'd5;
  logic [CW-1:0] yellow_time = 7'd2;
  logic [CW-1:0] red_time    = 7'd3;
  logic          last_cnt;
  logic          sec_tick;
  logic [CW-1:0] remaining;
  logic [3:0]    rem_tens;
  logic [3:0]    rem_ones;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit last;
    int rem;
  } evt_t;
  evt_t sbQ[$];

  bit            openLoop   = 1'b0;
  logic [LW-1:0] manualInit = '0;
  phase_e        phase;
  logic [LW-1:0] fsmInit;
  logic [LW-1:0] light;

  traffic_phase_timer #(
    .CNT_WIDTH(CW),
    .TICK_DIV (TICK),
    .LIGHT_W  (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cnt_init   (cnt_init),
    .green_time (green_time),
    .yellow_time(yellow_time),
    .red_time   (red_time),
    .last_cnt   (last_cnt),
    .sec_tick   (sec_tick),
    .remaining  (remaining),
    .rem_tens   (rem_tens),
    .rem_ones   (rem_ones)
  );

  // Free-running clock and edge counter used to timestamp expected events.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for traffic_fsm: IDLE -> GREEN on enable, advances on last_cnt.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_IDLE;
    else if (!en) phase <= PH_IDLE;
    else begin
      case (phase)
        PH_IDLE:   phase <= PH_GREEN;
        PH_GREEN:  if (last_cnt) phase <= PH_YELLOW;
        PH_YELLOW: if (last_cnt) phase <= PH_RED;
        default:   if (last_cnt) phase <= PH_GREEN;
      endcase
    end
  end

  // FSM reaction to last_cnt and its light outputs.
  always_comb begin
    fsmInit = LIGHT_OFF;
    light   = LIGHT_OFF;
    case (phase)
      PH_GREEN:  begin light = LIGHT_GREEN;  if (en && last_cnt) fsmInit = LIGHT_YELLOW; end
      PH_YELLOW: begin light = LIGHT_YELLOW; if (en && last_cnt) fsmInit = LIGHT_RED;    end
      PH_RED:    begin light = LIGHT_RED;    if (en && last_cnt) fsmInit = LIGHT_GREEN;  end
      default:   begin light = LIGHT_OFF; end
    endcase
  end

  assign cnt_init = openLoop ? manualInit : fsmInit;

  // Hard time limit so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required finish before it", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic enV, input bit olV, input logic [LW-1:0] initV);
    en         = enV;
    openLoop   = olV;
    manualInit = initV;
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Expected pulses for a phase of n seconds loaded on edge loadEdge.
  task automatic pushPhase(input int loadEdge, input int n);
    evt_t e;
    for (int j = 1; j <= n; j++) begin
      e.cyc  = loadEdge + TICK * j;
      e.last = (j == n);
      e.rem  = n - j;
      sbQ.push_back(e);
    end
  endtask

  task automatic monitorLoop();
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (sec_tick || last_cnt)) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpectedPulse: got tick %0b last %0b at cycle %0d, expected no pulse",
                   sec_tick, last_cnt, cyc);
        end else begin
          e = sbQ.pop_front();
          if (cyc != e.cyc || last_cnt != e.last || !sec_tick || int'(remaining) != e.rem) begin
            errors++;
            $display("[TB] FAIL scoreboard: got cycle %0d tick %0b last %0b rem %0d, expected cycle %0d tick 1 last %0b rem %0d",
                     cyc, sec_tick, last_cnt, remaining, e.cyc, e.last, e.rem);
          end
        end
      end
    end
  endtask

  initial begin
    int l0, l1, l2, l3, l4, l5;
    evt_t e;
    fork
      monitorLoop();
    join_none

    // Reset held with enable low.
    repeat (3) @(negedge clk);
    checkOutput("rstLast", int'(last_cnt), 0);
    checkOutput("rstTick", int'(sec_tick), 0);
    checkOutput("rstRem", int'(remaining), 0);
    checkOutput("rstTens", int'(rem_tens), 0);
    checkOutput("rstOnes", int'(rem_ones), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idleRem", int'(remaining), 0);
    checkOutput("idleLast", int'(last_cnt), 0);

    // Closed loop: green 5, yellow 2, red 3, green again.
    l0 = cyc + 1;
    pushPhase(l0, 5);
    pushPhase(l0 + 21, 2);
    pushPhase(l0 + 30, 3);
    pushPhase(l0 + 43, 5);
    applyStimulus(1'b1, 1'b0, LIGHT_OFF);
    waitCycle(l0);
    checkOutput("greenLoad", int'(remaining), 5);
    checkOutput("greenOnes", int'(rem_ones), 5);
    checkOutput("greenLight", int'(light), int'(LIGHT_GREEN));
    waitCycle(l0 + 20);
    checkOutput("greenLast", int'(last_cnt), 1);
    waitCycle(l0 + 21);
    checkOutput("yellowLight", int'(light), int'(LIGHT_YELLOW));
    checkOutput("yellowLoad", int'(remaining), 2);
    checkOutput("lastWidth", int'(last_cnt), 0);
    waitCycle(l0 + 30);
    checkOutput("redLight", int'(light), int'(LIGHT_RED));
    checkOutput("redLoad", int'(remaining), 3);
    waitCycle(l0 + 43);
    checkOutput("green2Light", int'(light), int'(LIGHT_GREEN));
    checkOutput("green2Load", int'(remaining), 5);
    waitCycle(l0 + 50);
    green_time = 7'd8;
    waitCycle(l0 + 64);
    checkOutput("yellow2Load", int'(remaining), 2);

    // Enable dropped mid-yellow.
    waitCycle(l0 + 66);
    applyStimulus(1'b0, 1'b0, LIGHT_OFF);
    waitCycle(l0 + 67);
    checkOutput("enDropRem", int'(remaining), 0);
    checkOutput("enDropLast", int'(last_cnt), 0);
    checkOutput("enDropLight", int'(light), int'(LIGHT_OFF));

    // Re-arm in open loop and let the phase expire with no reload.
    waitCycle(l0 + 72);
    green_time = 7'd5;
    l1 = cyc + 1;
    pushPhase(l1, 5);
    applyStimulus(1'b1, 1'b1, LIGHT_OFF);
    waitCycle(l1);
    checkOutput("rearmLoad", int'(remaining), 5);
    waitCycle(l1 + 70);
    checkOutput("expiredRem", int'(remaining), 0);
    checkOutput("expiredLast", int'(last_cnt), 0);

    // Multi-hot yellow|red selects yellow.
    l2 = cyc + 1;
    pushPhase(l2, 2);
    applyStimulus(1'b1, 1'b1, 3'b011);
    waitCycle(l2);
    checkOutput("multiHotYR", int'(remaining), 2);
    applyStimulus(1'b1, 1'b1, LIGHT_OFF);
    waitCycle(l2 + 12);

    // Two-digit BCD, reload during RUN, and zero red duration.
    green_time = 7'd37;
    red_time   = 7'd0;
    l3 = cyc + 1;
    applyStimulus(1'b1, 1'b1, LIGHT_GREEN);
    waitCycle(l3);
    checkOutput("load37", int'(remaining), 37);
    checkOutput("tens37", int'(rem_tens), 3);
    checkOutput("ones37", int'(rem_ones), 7);
    l4 = l3 + 1;
    pushPhase(l4, 1);
    applyStimulus(1'b1, 1'b1, LIGHT_RED);
    waitCycle(l4);
    checkOutput("redZeroLoad", int'(remaining), 1);
    applyStimulus(1'b1, 1'b1, LIGHT_OFF);
    waitCycle(l4 + 8);

    // Saturated display, green priority, then async reset mid-run.
    green_time = 7'd123;
    l5 = cyc + 1;
    e.cyc  = l5 + TICK;
    e.last = 1'b0;
    e.rem  = 122;
    sbQ.push_back(e);
    applyStimulus(1'b1, 1'b1, 3'b110);
    waitCycle(l5);
    checkOutput("load123", int'(remaining), 123);
    checkOutput("tensSat", int'(rem_tens), 9);
    checkOutput("onesSat", int'(rem_ones), 9);
    applyStimulus(1'b1, 1'b1, LIGHT_OFF);
    waitCycle(l5 + 6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRem", int'(remaining), 0);
    checkOutput("asyncLast", int'(last_cnt), 0);
    checkOutput("asyncTick", int'(sec_tick), 0);
    checkOutput("asyncTens", int'(rem_tens), 0);
    checkOutput("asyncOnes", int'(rem_ones), 0);

    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
